// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the accumulator CPU control path: bus selects, opcodes,
// ALU operations, sequencer state and sequence-counter width.
package cpu_ctrl_pkg;

    localparam int SC_W  = 3;
    localparam int OPC_W = 3;

    localparam logic [2:0] SEL_X   = 3'b000;
    localparam logic [2:0] SEL_AR  = 3'b001;
    localparam logic [2:0] SEL_PC  = 3'b010;
    localparam logic [2:0] SEL_DR  = 3'b011;
    localparam logic [2:0] SEL_AC  = 3'b100;
    localparam logic [2:0] SEL_IR  = 3'b101;
    localparam logic [2:0] SEL_TR  = 3'b110;
    localparam logic [2:0] SEL_MEM = 3'b111;

    localparam logic [OPC_W-1:0] OP_AND = 3'b000;
    localparam logic [OPC_W-1:0] OP_ADD = 3'b001;
    localparam logic [OPC_W-1:0] OP_LDA = 3'b010;
    localparam logic [OPC_W-1:0] OP_STA = 3'b011;
    localparam logic [OPC_W-1:0] OP_BUN = 3'b100;
    localparam logic [OPC_W-1:0] OP_ISZ = 3'b101;
    localparam logic [OPC_W-1:0] OP_REG = 3'b110;
    localparam logic [OPC_W-1:0] OP_HLT = 3'b111;

    localparam logic [2:0] ALU_PASS_DR = 3'b000;
    localparam logic [2:0] ALU_AND     = 3'b001;
    localparam logic [2:0] ALU_ADD     = 3'b010;
    localparam logic [2:0] ALU_CLR     = 3'b011;
    localparam logic [2:0] ALU_CMP     = 3'b100;
    localparam logic [2:0] ALU_INC     = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    // Register-op action bits are prioritised: the lowest set bit wins.
    function automatic logic [4:0] lowest_set(input logic [4:0] v);
        return v & (~v + 5'd1);
    endfunction

endpackage

// File: rtl/control_sequencer_seq_counter.sv
// T-step counter for the control sequencer: synchronous clear has priority
// over increment, otherwise the count holds.
module seq_counter
    import cpu_ctrl_pkg::*;
#(
    parameter int W = SC_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (inc_i) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/control_sequencer.sv
// Timing and control unit of the accumulator CPU: decodes state, T-step, IR and
// flags into bus select and register/memory strobes. Option: SINGLE_STEP_EN.
//
//  state   | meaning
//  --------+-------------------------------------------------------------
//  ST_IDLE | after reset (or after each instruction when single-stepping)
//  ST_RUN  | executing; SC counts the T-steps of the current instruction
//  ST_HALT | HLT executed; only START or reset leaves it
module control_sequencer
    import cpu_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            START,
`ifdef SINGLE_STEP_EN
    input  logic            STEP,
`endif
    input  logic [7:0]      IR_DATA,
    input  logic            AC_ZERO,
    input  logic            AC_SIGN,
    input  logic            DR_ZERO,
    output logic [2:0]      BUS_SEL,
    output logic            AR_LD,
    output logic            PC_LD,
    output logic            DR_LD,
    output logic            AC_LD,
    output logic            IR_LD,
    output logic            TR_LD,
    output logic            PC_INR,
    output logic            DR_INR,
    output logic            MEM_WR,
    output logic [2:0]      ALU_OP,
    output logic [SC_W-1:0] SC,
    output logic            HALTED
);

    state_e            state_q;
    state_e            state_d;
    logic [SC_W-1:0]   sc;
    logic              sc_clr;
    logic              sc_inc;
    logic              instr_done;
    logic              run_req;
    logic [OPC_W-1:0]  opc;
    logic [4:0]        reg_act;
    logic              skip;

    assign opc     = IR_DATA[7:5];
    assign reg_act = lowest_set(IR_DATA[4:0]);
    assign skip    = (reg_act[3] & AC_ZERO) | (reg_act[4] & AC_SIGN);

`ifdef SINGLE_STEP_EN
    assign run_req = START | STEP;
`else
    assign run_req = START;
`endif

    seq_counter #(.W(SC_W)) u_sc (
        .clk   (clk),
        .rst   (reset),
        .clr_i (sc_clr),
        .inc_i (sc_inc),
        .cnt_o (sc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        sc_clr     = 1'b0;
        sc_inc     = 1'b0;
        instr_done = 1'b0;
        BUS_SEL    = SEL_X;
        ALU_OP     = ALU_PASS_DR;
        AR_LD      = 1'b0;
        PC_LD      = 1'b0;
        DR_LD      = 1'b0;
        AC_LD      = 1'b0;
        IR_LD      = 1'b0;
        TR_LD      = 1'b0;
        PC_INR     = 1'b0;
        DR_INR     = 1'b0;
        MEM_WR     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (run_req) begin
                    state_d = ST_RUN;
                    sc_clr  = 1'b1;
                end
            end
            ST_HALT: begin
                if (START) begin
                    state_d = ST_RUN;
                    sc_clr  = 1'b1;
                end
            end
            ST_RUN: begin
                case (sc)
                    3'd0: begin
                        BUS_SEL = SEL_PC;
                        AR_LD   = 1'b1;
                        sc_inc  = 1'b1;
                    end
                    3'd1: begin
                        BUS_SEL = SEL_MEM;
                        IR_LD   = 1'b1;
                        PC_INR  = 1'b1;
                        sc_inc  = 1'b1;
                    end
                    3'd2: begin
                        if (opc == OP_REG) begin
                            if (reg_act[0]) begin
                                ALU_OP = ALU_CLR;
                                AC_LD  = 1'b1;
                            end
                            if (reg_act[1]) begin
                                ALU_OP = ALU_CMP;
                                AC_LD  = 1'b1;
                            end
                            if (reg_act[2]) begin
                                ALU_OP = ALU_INC;
                                AC_LD  = 1'b1;
                            end
                            PC_INR = skip;
                            if (skip) begin
                                sc_inc = 1'b1;
                            end else begin
                                instr_done = 1'b1;
                            end
                        end else if (opc == OP_HLT) begin
                            state_d = ST_HALT;
                            sc_clr  = 1'b1;
                        end else begin
                            BUS_SEL = SEL_PC;
                            AR_LD   = 1'b1;
                            sc_inc  = 1'b1;
                        end
                    end
                    3'd3: begin
                        // Register ops only reach T3 on a taken skip.
                        if (opc == OP_REG) begin
                            PC_INR     = 1'b1;
                            instr_done = 1'b1;
                        end else begin
                            BUS_SEL = SEL_MEM;
                            AR_LD   = 1'b1;
                            PC_INR  = 1'b1;
                            sc_inc  = 1'b1;
                        end
                    end
                    3'd4: begin
                        case (opc)
                            OP_AND, OP_ADD, OP_LDA, OP_ISZ: begin
                                BUS_SEL = SEL_MEM;
                                DR_LD   = 1'b1;
                                sc_inc  = 1'b1;
                            end
                            OP_STA: begin
                                BUS_SEL    = SEL_AC;
                                MEM_WR     = 1'b1;
                                instr_done = 1'b1;
                            end
                            OP_BUN: begin
                                BUS_SEL    = SEL_AR;
                                PC_LD      = 1'b1;
                                instr_done = 1'b1;
                            end
                            default: instr_done = 1'b1;
                        endcase
                    end
                    3'd5: begin
                        case (opc)
                            OP_AND: begin
                                ALU_OP     = ALU_AND;
                                AC_LD      = 1'b1;
                                instr_done = 1'b1;
                            end
                            OP_ADD: begin
                                ALU_OP     = ALU_ADD;
                                AC_LD      = 1'b1;
                                instr_done = 1'b1;
                            end
                            OP_LDA: begin
                                ALU_OP     = ALU_PASS_DR;
                                AC_LD      = 1'b1;
                                instr_done = 1'b1;
                            end
                            OP_ISZ: begin
                                DR_INR = 1'b1;
                                sc_inc = 1'b1;
                            end
                            default: instr_done = 1'b1;
                        endcase
                    end
                    3'd6: begin
                        if (opc == OP_ISZ) begin
                            BUS_SEL = SEL_DR;
                            MEM_WR  = 1'b1;
                            PC_INR  = DR_ZERO;
                            if (DR_ZERO) begin
                                sc_inc = 1'b1;
                            end else begin
                                instr_done = 1'b1;
                            end
                        end else begin
                            instr_done = 1'b1;
                        end
                    end
                    3'd7: begin
                        PC_INR     = (opc == OP_ISZ);
                        instr_done = 1'b1;
                    end
                    default: instr_done = 1'b1;
                endcase
            end
            default: state_d = ST_IDLE;
        endcase

        if (instr_done) begin
            sc_clr = 1'b1;
`ifdef SINGLE_STEP_EN
            state_d = ST_IDLE;
`endif
        end
    end

    assign SC     = sc;
    assign HALTED = (state_q == ST_HALT);

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: a small datapath driven by the strobes, directed
// step traces, and a random-program run checked against an instruction-level model.
module tb_control_sequencer;

    localparam logic [8:0] S_AR   = 9'h100;
    localparam logic [8:0] S_PCLD = 9'h080;
    localparam logic [8:0] S_DRLD = 9'h040;
    localparam logic [8:0] S_ACLD = 9'h020;
    localparam logic [8:0] S_IR   = 9'h010;
    localparam logic [8:0] S_PCI  = 9'h004;
    localparam logic [8:0] S_DRI  = 9'h002;
    localparam logic [8:0] S_MW   = 9'h001;
    localparam logic [8:0] BUS_USERS = 9'h1D9;

    localparam logic [2:0] B_X = 3'd0, B_AR = 3'd1, B_PC = 3'd2, B_DR = 3'd3;
    localparam logic [2:0] B_AC = 3'd4, B_MEM = 3'd7;

    logic       clk = 1'b0;
    logic       reset;
    logic       START;
    logic [7:0] IR_DATA;
    logic       AC_ZERO, AC_SIGN, DR_ZERO;
    logic [2:0] BUS_SEL, ALU_OP, SC;
    logic       AR_LD, PC_LD, DR_LD, AC_LD, IR_LD, TR_LD, PC_INR, DR_INR, MEM_WR;
    logic       HALTED;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    control_sequencer dut (
        .clk     (clk),
        .reset   (reset),
        .START   (START),
        .IR_DATA (IR_DATA),
        .AC_ZERO (AC_ZERO),
        .AC_SIGN (AC_SIGN),
        .DR_ZERO (DR_ZERO),
        .BUS_SEL (BUS_SEL),
        .AR_LD   (AR_LD),
        .PC_LD   (PC_LD),
        .DR_LD   (DR_LD),
        .AC_LD   (AC_LD),
        .IR_LD   (IR_LD),
        .TR_LD   (TR_LD),
        .PC_INR  (PC_INR),
        .DR_INR  (DR_INR),
        .MEM_WR  (MEM_WR),
        .ALU_OP  (ALU_OP),
        .SC      (SC),
        .HALTED  (HALTED)
    );

    // Datapath that obeys the strobes
    logic [7:0] mem [256];
    logic [7:0] img [256];
    logic [7:0] ar, pc, dr, ac, ir, tr, init_ac, bus;
    logic       load_req = 1'b0;

    always_comb begin
        case (BUS_SEL)
            3'd1:    bus = ar;
            3'd2:    bus = pc;
            3'd3:    bus = dr;
            3'd4:    bus = ac;
            3'd5:    bus = ir;
            3'd6:    bus = tr;
            3'd7:    bus = mem[ar];
            default: bus = 8'h00;
        endcase
    end

    always @(posedge clk) begin
        if (load_req) begin
            for (int i = 0; i < 256; i++) mem[i] <= img[i];
            ar <= 8'h00; pc <= 8'h00; dr <= 8'h00; ir <= 8'h00; tr <= 8'h00;
            ac <= init_ac;
        end else begin
            if (AR_LD) ar <= bus;
            if (PC_LD) pc <= bus;
            else if (PC_INR) pc <= pc + 8'd1;
            if (DR_LD) dr <= bus;
            else if (DR_INR) dr <= dr + 8'd1;
            if (AC_LD) begin
                case (ALU_OP)
                    3'd1:    ac <= ac & dr;
                    3'd2:    ac <= ac + dr;
                    3'd3:    ac <= 8'h00;
                    3'd4:    ac <= ~ac;
                    3'd5:    ac <= ac + 8'd1;
                    default: ac <= dr;
                endcase
            end
            if (IR_LD) ir <= bus;
            if (TR_LD) tr <= bus;
            if (MEM_WR) mem[ar] <= bus;
        end
    end

    assign IR_DATA = ir;
    assign AC_ZERO = (ac == 8'h00);
    assign AC_SIGN = ac[7];
    assign DR_ZERO = (dr == 8'h00);

    function automatic logic [8:0] stb_v();
        return {AR_LD, PC_LD, DR_LD, AC_LD, IR_LD, TR_LD, PC_INR, DR_INR, MEM_WR};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        START = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic load_prog();
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
    endtask

    task automatic clear_img(input logic [7:0] acv);
        for (int i = 0; i < 256; i++) img[i] = 8'h00;
        init_ac = acv;
    endtask

    task automatic kick();
        START = 1'b1;
        tick();
        START = 1'b0;
    endtask

    // Instruction-level reference model
    logic [7:0] m_mem [256];
    logic [7:0] m_pc, m_ac;

    task automatic isa_step(output int cyc, output bit hl);
        logic [7:0] ins, opd, v;
        ins = m_mem[m_pc];
        m_pc = m_pc + 8'd1;
        hl = 1'b0;
        cyc = 3;
        if (ins[7:5] == 3'b110) begin
            if (ins[0]) m_ac = 8'h00;
            else if (ins[1]) m_ac = ~m_ac;
            else if (ins[2]) m_ac = m_ac + 8'd1;
            else if ((ins[3] && m_ac == 8'h00) || (!ins[3] && ins[4] && m_ac[7])) begin
                m_pc = m_pc + 8'd2;
                cyc = 4;
            end
        end else if (ins[7:5] == 3'b111) begin
            hl = 1'b1;
        end else begin
            opd = m_mem[m_pc];
            m_pc = m_pc + 8'd1;
            case (ins[7:5])
                3'b000: begin m_ac = m_ac & m_mem[opd]; cyc = 6; end
                3'b001: begin m_ac = m_ac + m_mem[opd]; cyc = 6; end
                3'b010: begin m_ac = m_mem[opd]; cyc = 6; end
                3'b011: begin m_mem[opd] = m_ac; cyc = 5; end
                3'b100: begin m_pc = opd; cyc = 5; end
                default: begin
                    v = m_mem[opd] + 8'd1;
                    m_mem[opd] = v;
                    if (v == 8'h00) begin m_pc = m_pc + 8'd2; cyc = 8; end
                    else cyc = 7;
                end
            endcase
        end
    endtask

    task automatic test_reset();
        do_reset();
        clear_img(8'h77);
        img[0] = 8'h60; img[1] = 8'h40; img[8'h40] = 8'h11;
        load_prog();
        kick();
        repeat (4) tick();
        total++;
        if (SC !== 3'd4 || MEM_WR !== 1'b1 || BUS_SEL !== B_AC) begin
            bad++;
            $display("FAIL sta_t4: got sc=%0d mem_wr=%b bus=%0d, want sc=4 mem_wr=1 bus=4", SC, MEM_WR, BUS_SEL);
        end
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (stb_v() !== 9'h0 || BUS_SEL !== B_X || ALU_OP !== 3'd0 || SC !== 3'd0 || HALTED !== 1'b0) begin
            bad++;
            $display("FAIL reset_async: got stb=%03h bus=%0d alu=%0d sc=%0d halted=%b, want all 0", stb_v(), BUS_SEL, ALU_OP, SC, HALTED);
        end
        tick();
        total++;
        if (mem[8'h40] !== 8'h11) begin
            bad++;
            $display("FAIL reset_no_write: got mem=%02h, want 11", mem[8'h40]);
        end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (stb_v() !== 9'h0 || BUS_SEL !== B_X || SC !== 3'd0 || HALTED !== 1'b0) begin
                bad++;
                $display("FAIL reset_idle %0d: got stb=%03h bus=%0d sc=%0d halted=%b, want all 0", i, stb_v(), BUS_SEL, SC, HALTED);
            end
        end
    endtask

    task automatic test_lda();
        logic [8:0] es [6];
        logic [2:0] eb [6];
        logic [2:0] ea [6];
        es = '{S_AR, S_IR | S_PCI, S_AR, S_AR | S_PCI, S_DRLD, S_ACLD};
        eb = '{B_PC, B_MEM, B_PC, B_MEM, B_MEM, B_X};
        ea = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
        do_reset();
        clear_img(8'h00);
        img[0] = 8'h40; img[1] = 8'h10; img[8'h10] = 8'h5A;
        load_prog();
        kick();
        for (int i = 0; i < 6; i++) begin
            total++;
            if (SC !== 3'(i) || stb_v() !== es[i] || ((es[i] & BUS_USERS) != 9'h0 && BUS_SEL !== eb[i])
                || (es[i][5] && ALU_OP !== ea[i])) begin
                bad++;
                $display("FAIL lda_trace T%0d: got sc=%0d bus=%0d stb=%03h alu=%0d, want bus=%0d stb=%03h alu=%0d",
                         i, SC, BUS_SEL, stb_v(), ALU_OP, eb[i], es[i], ea[i]);
            end
            tick();
        end
        total++;
        if (pc !== 8'h02 || ac !== 8'h5A) begin
            bad++;
            $display("FAIL lda_result: got pc=%02h ac=%02h, want pc=02 ac=5a", pc, ac);
        end
        total++;
        if (SC !== 3'd0 || HALTED !== 1'b0 || stb_v() !== S_AR || BUS_SEL !== B_PC) begin
            bad++;
            $display("FAIL lda_next_t0: got sc=%0d halted=%b stb=%03h bus=%0d, want sc=0 stb=100 bus=2", SC, HALTED, stb_v(), BUS_SEL);
        end
    endtask

    task automatic test_add_sza();
        logic [8:0] es [10];
        logic [2:0] eb [10];
        logic [2:0] ea [10];
        es = '{S_AR, S_IR | S_PCI, S_AR, S_AR | S_PCI, S_DRLD, S_ACLD,
               S_AR, S_IR | S_PCI, S_PCI, S_PCI};
        eb = '{B_PC, B_MEM, B_PC, B_MEM, B_MEM, B_X, B_PC, B_MEM, B_X, B_X};
        ea = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd2, 3'd0, 3'd0, 3'd0, 3'd0};
        do_reset();
        clear_img(8'hFF);
        img[0] = 8'h20; img[1] = 8'h30; img[8'h30] = 8'h01;
        img[2] = 8'hC8; img[5] = 8'hE0;
        load_prog();
        kick();
        for (int i = 0; i < 10; i++) begin
            if (i == 6) begin
                total++;
                if (ac !== 8'h00 || AC_ZERO !== 1'b1) begin
                    bad++;
                    $display("FAIL add_wrap: got ac=%02h, want 00", ac);
                end
            end
            total++;
            if (SC !== 3'(i < 6 ? i : i - 6) || stb_v() !== es[i]
                || ((es[i] & BUS_USERS) != 9'h0 && BUS_SEL !== eb[i])
                || (es[i][5] && ALU_OP !== ea[i])) begin
                bad++;
                $display("FAIL add_sza_trace %0d: got sc=%0d bus=%0d stb=%03h alu=%0d, want bus=%0d stb=%03h alu=%0d",
                         i, SC, BUS_SEL, stb_v(), ALU_OP, eb[i], es[i], ea[i]);
            end
            tick();
        end
        total++;
        if (SC !== 3'd0 || pc !== 8'h05) begin
            bad++;
            $display("FAIL sza_skip: got sc=%0d pc=%02h, want sc=0 pc=05", SC, pc);
        end
        repeat (3) tick();
        total++;
        if (HALTED !== 1'b1 || stb_v() !== 9'h0 || SC !== 3'd0) begin
            bad++;
            $display("FAIL hlt_after_skip: got halted=%b stb=%03h sc=%0d, want halted=1 stb=000 sc=0", HALTED, stb_v(), SC);
        end
    endtask

    task automatic test_isz();
        logic [8:0] es [8];
        logic [2:0] eb [8];
        for (int pass = 0; pass < 2; pass++) begin
            es = '{S_AR, S_IR | S_PCI, S_AR, S_AR | S_PCI, S_DRLD, S_DRI,
                   (pass == 0) ? (S_MW | S_PCI) : S_MW, S_PCI};
            eb = '{B_PC, B_MEM, B_PC, B_MEM, B_MEM, B_X, B_DR, B_X};
            do_reset();
            clear_img(8'h00);
            img[0] = 8'hA0; img[1] = 8'h20; img[8'h20] = (pass == 0) ? 8'hFF : 8'h05;
            load_prog();
            kick();
            for (int i = 0; i < ((pass == 0) ? 8 : 7); i++) begin
                total++;
                if (SC !== 3'(i) || stb_v() !== es[i] || ((es[i] & BUS_USERS) != 9'h0 && BUS_SEL !== eb[i])) begin
                    bad++;
                    $display("FAIL isz_trace p%0d T%0d: got sc=%0d bus=%0d stb=%03h, want bus=%0d stb=%03h",
                             pass, i, SC, BUS_SEL, stb_v(), eb[i], es[i]);
                end
                tick();
            end
            total++;
            if (SC !== 3'd0 || mem[8'h20] !== ((pass == 0) ? 8'h00 : 8'h06) || pc !== ((pass == 0) ? 8'h04 : 8'h02)) begin
                bad++;
                $display("FAIL isz_result p%0d: got sc=%0d mem=%02h pc=%02h", pass, SC, mem[8'h20], pc);
            end
        end
    endtask

    task automatic test_bun_hlt();
        logic [8:0] es [8];
        logic [2:0] eb [8];
        es = '{S_AR, S_IR | S_PCI, S_AR, S_AR | S_PCI, S_PCLD, S_AR, S_IR | S_PCI, 9'h000};
        eb = '{B_PC, B_MEM, B_PC, B_MEM, B_AR, B_PC, B_MEM, B_X};
        do_reset();
        clear_img(8'h00);
        img[0] = 8'h80; img[1] = 8'h80; img[8'h80] = 8'hE0;
        load_prog();
        kick();
        for (int i = 0; i < 8; i++) begin
            total++;
            if (SC !== 3'(i < 5 ? i : i - 5) || stb_v() !== es[i]
                || ((es[i] & BUS_USERS) != 9'h0 && BUS_SEL !== eb[i])) begin
                bad++;
                $display("FAIL bun_hlt_trace %0d: got sc=%0d bus=%0d stb=%03h, want bus=%0d stb=%03h",
                         i, SC, BUS_SEL, stb_v(), eb[i], es[i]);
            end
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (HALTED !== 1'b1 || SC !== 3'd0 || stb_v() !== 9'h0 || BUS_SEL !== B_X || pc !== 8'h81) begin
                bad++;
                $display("FAIL halt_hold %0d: got halted=%b sc=%0d stb=%03h bus=%0d pc=%02h", i, HALTED, SC, stb_v(), BUS_SEL, pc);
            end
            tick();
        end
        kick();
        total++;
        if (HALTED !== 1'b0 || SC !== 3'd0 || stb_v() !== S_AR || BUS_SEL !== B_PC) begin
            bad++;
            $display("FAIL halt_resume: got halted=%b sc=%0d stb=%03h bus=%0d, want halted=0 sc=0 stb=100 bus=2", HALTED, SC, stb_v(), BUS_SEL);
        end
    endtask

    task automatic test_regop();
        do_reset();
        clear_img(8'h55);
        img[0] = 8'hC3;
        load_prog();
        kick();
        tick();
        tick();
        total++;
        if (SC !== 3'd2 || stb_v() !== S_ACLD || ALU_OP !== 3'd3) begin
            bad++;
            $display("FAIL regop_t2: got sc=%0d stb=%03h alu=%0d, want sc=2 stb=020 alu=3", SC, stb_v(), ALU_OP);
        end
        tick();
        total++;
        if (SC !== 3'd0 || ac !== 8'h00 || pc !== 8'h01 || stb_v() !== S_AR) begin
            bad++;
            $display("FAIL regop_done: got sc=%0d ac=%02h pc=%02h stb=%03h, want sc=0 ac=00 pc=01 stb=100", SC, ac, pc, stb_v());
        end
    endtask

    task automatic test_random();
        int  cyc;
        bit  hl;
        int  diff;
        do_reset();
        for (int i = 0; i < 256; i++) img[i] = 8'($urandom);
        init_ac = 8'($urandom);
        load_prog();
        for (int i = 0; i < 256; i++) m_mem[i] = img[i];
        m_pc = 8'h00;
        m_ac = init_ac;
        START = 1'b1;
        tick();
        for (int n = 0; n < 250; n++) begin
            isa_step(cyc, hl);
            repeat (cyc) tick();
            total++;
            if (SC !== 3'd0 || HALTED !== hl || pc !== m_pc || ac !== m_ac) begin
                bad++;
                $display("FAIL random_instr %0d: got sc=%0d halted=%b pc=%02h ac=%02h, want sc=0 halted=%b pc=%02h ac=%02h",
                         n, SC, HALTED, pc, ac, hl, m_pc, m_ac);
            end
            diff = -1;
            for (int a = 0; a < 256; a++) if (diff < 0 && mem[a] !== m_mem[a]) diff = a;
            total++;
            if (diff >= 0) begin
                bad++;
                $display("FAIL random_mem %0d: addr %02h got %02h, want %02h", n, diff, mem[diff], m_mem[diff]);
            end
            if (hl) tick();
        end
        START = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        START = 1'b0;
        init_ac = 8'h00;
        test_reset();
        test_lda();
        test_add_sza();
        test_isz();
        test_bun_hlt();
        test_regop();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
